fetch_unit: RTL and testbench

- Instruction-fetch and PC-sequencing stage for the single-cycle MIPS core.
- Drives instruction memory through a req/valid handshake and latches the returned word.
- Presents op/func and immediates to the decoder, then consumes the decoder's pcsel and Z-resolved branch decision to compute the next PC.
- Converts the core into a multi-cycle fetch/execute sequencer tolerant of variable-latency instruction memory.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch and PC sequencer with variable-latency memory handshake
module fetch_unit #(
    parameter logic [31:0] PC_INIT  = 32'h0040_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pcsel,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic        timeout
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic [WAIT_W-1:0] r_wait;
    logic              r_misalign;
    logic              r_timeout;
    logic [31:0]       w_next_pc;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_br_off;
    logic              w_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // REQ ignores enable so an outstanding response is never dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (enable)     w_next_state = S_REQ;
            S_REQ:   if (imem_valid) w_next_state = S_EXEC;
            S_EXEC:  if (enable)     w_next_state = S_REQ;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_take     = (r_state == S_EXEC) && enable;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pcsel)
            2'b01:   w_next_pc = w_pc_plus4 + w_br_off;
            2'b10:   w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            2'b11:   w_next_pc = {reg_target[31:2], 2'b00};
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= PC_INIT;
            r_instr    <= '0;
            r_wait     <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_take) begin
                r_pc <= w_next_pc;
                if ((pcsel == 2'b11) && (reg_target[1:0] != 2'b00)) begin
                    r_misalign <= 1'b1;
                end
            end
            // Wait counter saturates one past MAX_WAIT; the flag is sticky until reset.
            if (r_state == S_REQ) begin
                if (imem_valid) begin
                    r_instr <= imem_rdata;
                    r_wait  <= '0;
                end else if (r_wait != WAIT_SAT) begin
                    r_wait <= r_wait + 1'b1;
                    if (r_wait == WAIT_SAT - 1'b1) begin
                        r_timeout <= 1'b1;
                    end
                end
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign func        = r_instr[5:0];
    assign instr_valid = (r_state == S_EXEC);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misalign    = r_misalign;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory latency and next-PC selects
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT  = 32'h0040_0000;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  pcsel;
    logic [31:0] reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic        timeout;

    fetch_unit #(.PC_INIT(PC_INIT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pcsel(pcsel), .reg_target(reg_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .instr(instr), .op(op), .func(func),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misalign(misalign), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  pcsel;
        logic [31:0] target;
        logic [4:0]  lat;
        logic [1:0]  hold;
    } item_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        logic        to;
        logic [5:0]  req_len;
    } rec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_exec   = 0;
    logic        mon_en   = 1'b0;
    logic [31:0] exp_addr_q[$];
    rec_t        exp_exec_q[$];
    item_t       dir_q[$];

    item_t       cur;
    item_t       ex;
    logic        have_item = 1'b0;
    int          waited    = 0;
    int          ex_hold   = 0;
    logic [31:0] m_pc;
    logic        m_mis = 1'b0;
    logic        m_to  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.word   = $urandom;
        it.pcsel  = 2'($urandom_range(0, 3));
        it.target = $urandom;
        it.lat    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(16, 20)) : 5'($urandom_range(0, 3));
        it.hold   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        return it;
    endfunction

    function automatic item_t mk(input logic [31:0] w, input logic [1:0] s, input logic [31:0] t,
                                 input int lat, input int hold);
        item_t it;
        it.word = w; it.pcsel = s; it.target = t; it.lat = 5'(lat); it.hold = 2'(hold);
        return it;
    endfunction

    // Reference: next PC from the architectural rules, in plain arithmetic.
    task automatic model_commit(input item_t it);
        int off;
        case (it.pcsel)
            2'd0: m_pc = m_pc + 32'd4;
            2'd1: begin
                off  = $signed(it.word[15:0]);
                m_pc = m_pc + 32'd4 + 32'(off * 4);
            end
            2'd2: m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(it.word[25:0]) << 2);
            default: begin
                m_pc = it.target & 32'hFFFF_FFFC;
                if (it.target % 4 != 0) m_mis = 1'b1;
            end
        endcase
    endtask

    task automatic drive(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            pcsel      = 2'($urandom);
            reg_target = $urandom;
            imem_rdata = $urandom;
            if (imem_req) begin
                if (!have_item) begin
                    if (dir_q.size() > 0) cur = dir_q.pop_front();
                    else cur = rand_item();
                    have_item = 1'b1;
                    waited    = 0;
                end
                check("timeout_wait", 32'(timeout), 32'(m_to || (waited >= MAX_WAIT + 1)));
                enable = 1'($urandom);
                if (waited >= int'(cur.lat)) begin
                    imem_valid = 1'b1;
                    imem_rdata = cur.word;
                    if (int'(cur.lat) >= MAX_WAIT + 1) m_to = 1'b1;
                    exp_exec_q.push_back('{pc: m_pc, instr: cur.word, mis: m_mis, to: m_to,
                                           req_len: 6'(cur.lat) + 6'd1});
                    ex        = cur;
                    ex_hold   = int'(cur.hold);
                    have_item = 1'b0;
                end else begin
                    imem_valid = 1'b0;
                    waited++;
                end
            end else if (instr_valid) begin
                imem_valid = 1'($urandom);
                if (ex_hold > 0) begin
                    enable = 1'b0;
                    ex_hold--;
                end else begin
                    enable     = 1'b1;
                    pcsel      = ex.pcsel;
                    reg_target = ex.target;
                    model_commit(ex);
                    exp_addr_q.push_back(m_pc);
                end
            end else begin
                enable     = 1'b1;
                imem_valid = 1'($urandom);
            end
        end
    endtask

    initial begin : monitor
        logic        prev_req = 1'b0;
        logic        prev_iv  = 1'b0;
        int          req_cnt  = 0;
        logic [31:0] a;
        rec_t        r;
        r = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (imem_req) begin
                    if (!prev_req) begin
                        if (exp_addr_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
                        end else begin
                            a = exp_addr_q.pop_front();
                            check("fetch_addr", imem_addr, a);
                            check("fetch_pc", pc, a);
                        end
                        req_cnt = 1;
                    end else begin
                        req_cnt++;
                    end
                end
                if (instr_valid) begin
                    if (!prev_iv) begin
                        if (exp_exec_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL exec_unexpected: got instr %h expected no exec", instr);
                        end else begin
                            r = exp_exec_q.pop_front();
                            n_exec++;
                            check("exec_pc", pc, r.pc);
                            check("exec_instr", instr, r.instr);
                            check("op", 32'(op), 32'(r.instr[31:26]));
                            check("func", 32'(func), 32'(r.instr[5:0]));
                            check("pc_plus4", pc_plus4, r.pc + 32'd4);
                            check("misalign", 32'(misalign), 32'(r.mis));
                            check("timeout", 32'(timeout), 32'(r.to));
                            check("req_len", 32'(req_cnt), 32'(r.req_len));
                        end
                    end else begin
                        check("hold_pc", pc, r.pc);
                        check("hold_instr", instr, r.instr);
                    end
                end
            end
            prev_req = imem_req;
            prev_iv  = instr_valid;
        end
    end

    initial begin : main
        logic found;
        reset = 1'b0; enable = 1'b0; pcsel = 2'd0; reg_target = '0;
        imem_rdata = '0; imem_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, PC_INIT);
        check("rst_instr", instr, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);

        for (int i = 0; i < 4; i++) dir_q.push_back(mk($urandom, 2'd0, 32'h0, 0, 0));
        dir_q.push_back(mk(32'h1000_FFFE, 2'd1, 32'h0, 0, 0));
        dir_q.push_back(mk(32'h0810_0004, 2'd2, 32'h0, 0, 0));
        dir_q.push_back(mk(32'h1000_0003, 2'd1, 32'h0, 1, 0));
        dir_q.push_back(mk(32'h0810_0040, 2'd2, 32'h0, 0, 0));
        dir_q.push_back(mk(32'h0080_0008, 2'd3, 32'h0040_0023, 2, 0));
        dir_q.push_back(mk(32'h2108_0001, 2'd0, 32'h0, 4, 3));
        dir_q.push_back(mk(32'h2108_0002, 2'd0, 32'h0, 20, 0));

        m_pc = PC_INIT;
        exp_addr_q.push_back(PC_INIT);
        mon_en = 1'b1;
        reset  = 1'b0;
        drive(3000);
        mon_en = 1'b0;
        check("exec_count_min", 32'(n_exec >= 100), 32'h1);

        enable = 1'b1; imem_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            imem_valid = 1'b0;
            if (imem_req) found = 1'b1;
        end
        check("reach_req", 32'(found), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_pc", pc, PC_INIT);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_req", 32'(imem_req), 32'h0);
        check("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_flags", {30'h0, misalign, timeout}, 32'h0);
        reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; enable = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(imem_req), 32'h1);
        check("post_rst_addr", imem_addr, PC_INIT);
        check("post_rst_not_latched", instr, 32'h0);
        imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("post_rst_exec", 32'(instr_valid), 32'h1);
        check("post_rst_instr", instr, 32'h1234_5678);
        check("post_rst_pc", pc, PC_INIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
